// File: rtl/hazard_unit.sv
// Pipeline hazard unit: scoreboard-based operand forwarding, load-use stall
// and taken-branch flush sequencing for a 5-stage in-order core.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN  00  | normal issue; detect load-use and taken branches
// STALL 01 | one-cycle hold after load-use; load now in MEM, forward 10
// FLUSH 10 | ID holds the wrong-path instruction; squash it into EX

module hazard_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [4:0]  id_Rn,
   input  logic [4:0]  id_Ab,
   input  logic        id_use_Rn,
   input  logic        id_use_Ab,
   input  logic [4:0]  id_Rd,
   input  logic        id_RegWrite,
   input  logic        id_MemtoReg,
   input  logic        br_taken,
   output logic        stall_pc,
   output logic        stall_ifid,
   output logic        bubble_ex,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [1:0]  state,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   localparam logic [1:0] ST_RUN   = 2'b00;
   localparam logic [1:0] ST_STALL = 2'b01;
   localparam logic [1:0] ST_FLUSH = 2'b10;

   localparam logic [4:0]  XZR     = 5'd31;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   logic [1:0]  r_state;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   // The load flag only matters while the producer sits in EX.
   logic        r_ex_valid,  r_ex_rw,  r_ex_ld;
   logic [4:0]  r_ex_rd;
   logic        r_mem_valid, r_mem_rw;
   logic [4:0]  r_mem_rd;
   logic        r_wb_valid,  r_wb_rw;
   logic [4:0]  r_wb_rd;

   logic        w_live_a, w_live_b;
   logic        w_ex_a, w_mem_a, w_wb_a;
   logic        w_ex_b, w_mem_b, w_wb_b;
   logic        w_detect;
   logic        w_load_use;
   logic        w_flush_req;
   logic [1:0]  w_state_nxt;

   function automatic logic [1:0] fwd_sel(input logic live, input logic ex,
                                          input logic mem, input logic wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (live) begin
         if (ex)       sel = 2'b01;
         else if (mem) sel = 2'b10;
         else if (wb)  sel = 2'b11;
      end
      return sel;
   endfunction

   assign w_live_a = id_valid & id_use_Rn & (id_Rn != XZR);
   assign w_live_b = id_valid & id_use_Ab & (id_Ab != XZR);

   assign w_ex_a  = r_ex_valid  & r_ex_rw  & (r_ex_rd  == id_Rn);
   assign w_mem_a = r_mem_valid & r_mem_rw & (r_mem_rd == id_Rn);
   assign w_wb_a  = r_wb_valid  & r_wb_rw  & (r_wb_rd  == id_Rn);
   assign w_ex_b  = r_ex_valid  & r_ex_rw  & (r_ex_rd  == id_Ab);
   assign w_mem_b = r_mem_valid & r_mem_rw & (r_mem_rd == id_Ab);
   assign w_wb_b  = r_wb_valid  & r_wb_rw  & (r_wb_rd  == id_Ab);

   // Hazard logic is blind during reset and while squashing a wrong-path op.
   assign w_detect    = ~reset & (r_state != ST_FLUSH);
   assign w_load_use  = w_detect & r_ex_ld &
                        ((w_live_a & w_ex_a) | (w_live_b & w_ex_b));
   assign w_flush_req = w_detect & br_taken & ~w_load_use;

   assign stall_pc   = w_load_use;
   assign stall_ifid = w_load_use;
   assign bubble_ex  = reset | w_load_use | (r_state == ST_FLUSH);

   assign fwd_a = w_detect ? fwd_sel(w_live_a, w_ex_a, w_mem_a, w_wb_a) : 2'b00;
   assign fwd_b = w_detect ? fwd_sel(w_live_b, w_ex_b, w_mem_b, w_wb_b) : 2'b00;

   assign state     = r_state;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   always_comb begin
      w_state_nxt = ST_RUN;
      case (r_state)
         ST_FLUSH: w_state_nxt = ST_RUN;
         default: begin
            if (w_load_use)       w_state_nxt = ST_STALL;
            else if (w_flush_req) w_state_nxt = ST_FLUSH;
            else                  w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
         r_ex_valid  <= 1'b0;
         r_ex_rw     <= 1'b0;
         r_ex_ld     <= 1'b0;
         r_ex_rd     <= 5'd0;
         r_mem_valid <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_rd    <= 5'd0;
         r_wb_valid  <= 1'b0;
         r_wb_rw     <= 1'b0;
         r_wb_rd     <= 5'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_ex_valid  <= id_valid & ~bubble_ex;
         r_ex_rw     <= id_RegWrite;
         r_ex_ld     <= id_MemtoReg;
         r_ex_rd     <= id_Rd;
         r_mem_valid <= r_ex_valid;
         r_mem_rw    <= r_ex_rw;
         r_mem_rd    <= r_ex_rd;
         r_wb_valid  <= r_mem_valid;
         r_wb_rw     <= r_mem_rw;
         r_wb_rd     <= r_mem_rd;
         if (w_load_use && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush_req && (r_flush_cnt != CNT_MAX))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed test of hazard_unit: forwarding priority, load-use stall, XZR,
// branch flush, stall/branch collision, reset priority and counter saturation.

module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_Rn, id_Ab, id_Rd;
   logic        id_use_Rn, id_use_Ab, id_RegWrite, id_MemtoReg, br_taken;
   logic        stall_pc, stall_ifid, bubble_ex;
   logic [1:0]  fwd_a, fwd_b, state;
   logic [31:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   hazard_unit dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_Rn(id_Rn), .id_Ab(id_Ab), .id_use_Rn(id_use_Rn), .id_use_Ab(id_use_Ab),
      .id_Rd(id_Rd), .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
      .br_taken(br_taken), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
      .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ID instruction: valid, Rn, Ab, use_Rn, use_Ab, Rd, RegWrite, MemtoReg, br_taken
   task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] ab,
                         input logic urn, input logic uab, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic br);
      id_valid = v; id_Rn = rn; id_Ab = ab; id_use_Rn = urn; id_use_Ab = uab;
      id_Rd = rd; id_RegWrite = rw; id_MemtoReg = ld; br_taken = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_ctl(input string tag, input logic s, input logic b);
      check({tag, "_stall_pc"},   {31'd0, stall_pc},   {31'd0, s});
      check({tag, "_stall_ifid"}, {31'd0, stall_ifid}, {31'd0, s});
      check({tag, "_bubble_ex"},  {31'd0, bubble_ex},  {31'd0, b});
   endtask

   initial begin
      reset = 1'b1;
      set_id(1, 5'd3, 5'd3, 1, 1, 5'd3, 1, 0, 0);
      tick(); tick();
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_flush_cnt", flush_cnt, 32'd0);
      check_ctl("rst", 1'b0, 1'b1);
      check("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
      check("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
      reset = 1'b0;

      // Forwarding priority: SUB X3 -> MEM, ADD X3 -> EX
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
      set_id(1, 5'd3, 5'd2, 1, 0, 5'd7, 1, 0, 0);
      check("fwd_ex_a", {30'd0, fwd_a}, 32'd1);
      check_ctl("fwd_ex", 1'b0, 1'b0);
      tick();
      set_id(1, 5'd3, 5'd7, 1, 1, 5'd8, 1, 0, 0);
      check("fwd_mem_a", {30'd0, fwd_a}, 32'd2);
      check("fwd_ex_b", {30'd0, fwd_b}, 32'd1);
      tick();
      set_id(1, 5'd3, 5'd7, 1, 1, 5'd9, 1, 0, 0);
      check("fwd_wb_a", {30'd0, fwd_a}, 32'd3);
      check("fwd_mem_b", {30'd0, fwd_b}, 32'd2);
      set_id(1, 5'd3, 5'd7, 1, 0, 5'd9, 1, 0, 0);
      check("fwd_nouse_b", {30'd0, fwd_b}, 32'd0);
      set_id(0, 5'd3, 5'd7, 1, 1, 5'd9, 1, 0, 0);
      check("fwd_novalid_a", {30'd0, fwd_a}, 32'd0);
      set_id(1, 5'd3, 5'd7, 1, 1, 5'd9, 1, 0, 0);
      tick();
      check("fwd_none_a", {30'd0, fwd_a}, 32'd0);
      check("fwd_wb7_b", {30'd0, fwd_b}, 32'd3);
      idle(3);

      // Load-use: LDUR X5 in EX, ADD reads Ab=5
      set_id(1, 5'd1, 5'd2, 1, 0, 5'd5, 1, 1, 0); tick();
      set_id(1, 5'd1, 5'd5, 1, 1, 5'd6, 1, 0, 0);
      check_ctl("lu_detect", 1'b1, 1'b1);
      check("lu_detect_state", {30'd0, state}, 32'd0);
      tick();
      check("lu_stall_state", {30'd0, state}, 32'd1);
      check("lu_stall_fwd_b", {30'd0, fwd_b}, 32'd2);
      check_ctl("lu_stall", 1'b0, 1'b0);
      check("lu_stall_cnt", stall_cnt, 32'd1);
      tick();
      check("lu_run_state", {30'd0, state}, 32'd0);
      idle(3);

      // XZR never matches
      set_id(1, 5'd1, 5'd2, 1, 0, 5'd31, 1, 1, 0); tick();
      set_id(1, 5'd31, 5'd2, 1, 0, 5'd6, 1, 0, 0);
      check_ctl("xzr", 1'b0, 1'b0);
      check("xzr_fwd_a", {30'd0, fwd_a}, 32'd0);
      tick();
      check("xzr_state", {30'd0, state}, 32'd0);
      check("xzr_stall_cnt", stall_cnt, 32'd1);
      idle(3);

      // Taken branch -> FLUSH
      set_id(1, 5'd1, 5'd2, 1, 0, 5'd4, 1, 0, 1);
      check_ctl("br_run", 1'b0, 1'b0);
      tick();
      set_id(1, 5'd4, 5'd2, 1, 0, 5'd10, 1, 0, 1);
      check("br_flush_state", {30'd0, state}, 32'd2);
      check_ctl("br_flush", 1'b0, 1'b1);
      check("br_flush_fwd_a", {30'd0, fwd_a}, 32'd0);
      check("br_flush_cnt", flush_cnt, 32'd1);
      tick();
      set_id(1, 5'd4, 5'd10, 1, 1, 5'd11, 1, 0, 0);
      check("br_after_state", {30'd0, state}, 32'd0);
      check("br_after_flush_cnt", flush_cnt, 32'd1);
      check("br_after_fwd_a", {30'd0, fwd_a}, 32'd2);
      check("br_squashed_fwd_b", {30'd0, fwd_b}, 32'd0);
      idle(3);

      // Load-use and branch together: stall wins, branch resolves next cycle
      set_id(1, 5'd1, 5'd2, 1, 0, 5'd5, 1, 1, 0); tick();
      set_id(1, 5'd5, 5'd2, 1, 0, 5'd0, 0, 0, 1);
      check_ctl("sim_detect", 1'b1, 1'b1);
      tick();
      check("sim_state_stall", {30'd0, state}, 32'd1);
      check("sim_flush_cnt_hold", flush_cnt, 32'd1);
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("sim_state_flush", {30'd0, state}, 32'd2);
      check("sim_flush_cnt", flush_cnt, 32'd2);
      check("sim_stall_cnt", stall_cnt, 32'd2);
      tick();
      check("sim_state_run", {30'd0, state}, 32'd0);
      idle(3);

      // Reset while in STALL
      set_id(1, 5'd1, 5'd2, 1, 0, 5'd5, 1, 1, 0); tick();
      set_id(1, 5'd5, 5'd2, 1, 0, 5'd6, 1, 0, 0); tick();
      check("rs_state_stall", {30'd0, state}, 32'd1);
      reset = 1'b1; #1;
      check_ctl("rs_active", 1'b0, 1'b1);
      check("rs_active_fwd_a", {30'd0, fwd_a}, 32'd0);
      tick();
      reset = 1'b0; #1;
      check("rs_state", {30'd0, state}, 32'd0);
      check("rs_stall_cnt", stall_cnt, 32'd0);
      check("rs_flush_cnt", flush_cnt, 32'd0);
      check("rs_empty_fwd_a", {30'd0, fwd_a}, 32'd0);
      check_ctl("rs_after", 1'b0, 1'b0);
      idle(3);

      // Saturation: preset stall counter to all ones, then cause a load-use
      force dut.r_stall_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_stall_cnt;
      set_id(1, 5'd1, 5'd2, 1, 0, 5'd5, 1, 1, 0); tick();
      set_id(1, 5'd5, 5'd2, 1, 0, 5'd6, 1, 0, 0);
      check_ctl("sat_detect", 1'b1, 1'b1);
      tick();
      check("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
      check("sat_state", {30'd0, state}, 32'd1);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
